// File: rtl/mm_pkg.sv
// Shared definitions for the mm buffer responder: state encoding and the
// default feature/weight buffer geometries.
package mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SERVE = 2'b10,
    ST_DRAIN = 2'b11
  } mm_state_e;

  localparam int FEAT_DATA_W = 512;
  localparam int WGT_DATA_W  = 8192;
  localparam int FEAT_ADDR_W = 11;
  localparam int WGT_ADDR_W  = 13;

endpackage

// File: rtl/mm_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read.
// Indices are pre-qualified by the caller, so no range logic lives here.
module mm_sdp_ram #(
  parameter int DATA_W = 512,
  parameter int IDX_W  = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/mm_buf_responder.sv
// Read-side buffer responder: filled during LOAD, answers address requests
// during SERVE with a fixed RD_LAT-cycle latency, then drains in-flight reads.
module mm_buf_responder
  import mm_pkg::*;
#(
  parameter int DATA_W = FEAT_DATA_W,
  parameter int ADDR_W = FEAT_ADDR_W,
  parameter int DEPTH  = 2048,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_start,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              load_done,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              serve_done,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        state,
  output logic [15:0]       req_count,
  output logic              err_oob,
  output logic              err_proto
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  // Every valid stage except the output one: a response still to be presented.
  localparam logic [RD_LAT-1:0] PEND_MASK = RD_LAT'((1 << (RD_LAT-1)) - 1);

  mm_state_e         state_q, state_d;
  logic              enter_serve;
  logic              wr_ok, wr_in, accept, req_oob, proto_err, pending;
  logic [RD_LAT-1:0] vld_sr;
  logic              zero_q;
  logic [DATA_W-1:0] ram_q, ram_word;

  assign wr_ok     = (state_q == ST_LOAD) && wr_valid;
  assign wr_in     = {1'b0, wr_addr} < DEPTH_X;
  assign accept    = (state_q == ST_SERVE) && req_valid;
  assign req_oob   = {1'b0, req_addr} >= DEPTH_X;
  assign proto_err = (wr_valid && (state_q != ST_LOAD)) ||
                     (req_valid && (state_q != ST_SERVE));
  assign pending   = |(vld_sr & PEND_MASK);

  always_comb begin
    state_d     = state_q;
    enter_serve = 1'b0;
    case (state_q)
      ST_IDLE:  if (load_start) state_d = ST_LOAD;
      ST_LOAD:  if (load_done) begin
                  state_d     = ST_SERVE;
                  enter_serve = 1'b1;
                end
      ST_SERVE: if (serve_done) state_d = ST_DRAIN;
      ST_DRAIN: if (!pending) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      vld_sr    <= '0;
      zero_q    <= 1'b1;
      req_count <= '0;
      err_oob   <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_sr  <= (vld_sr << 1) | RD_LAT'(accept);
      // Out-of-range reads skip the RAM; this flag zeroes the word instead.
      if (accept) zero_q <= req_oob;
      if (enter_serve) req_count <= '0;
      else if (accept && (req_count != 16'hFFFF)) req_count <= req_count + 16'd1;
      if (accept && req_oob) err_oob <= 1'b1;
      if (proto_err) err_proto <= 1'b1;
    end
  end

  mm_sdp_ram #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok && wr_in),
    .wr_idx  (wr_addr[IDX_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (accept && !req_oob),
    .rd_idx  (req_addr[IDX_W-1:0]),
    .rd_data (ram_q)
  );

  assign ram_word = zero_q ? '0 : ram_q;

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign rsp_data = ram_word;
    end else begin : g_latn
      logic [DATA_W-1:0] dreg [RD_LAT-1];
      // Each stage loads only with its valid, so the output holds between responses.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int k = 0; k < RD_LAT-1; k++) dreg[k] <= '0;
        end else begin
          if (vld_sr[0]) dreg[0] <= ram_word;
          for (int k = 1; k < RD_LAT-1; k++) begin
            if (vld_sr[k]) dreg[k] <= dreg[k-1];
          end
        end
      end
      assign rsp_data = dreg[RD_LAT-2];
    end
  endgenerate

  assign rsp_valid = vld_sr[RD_LAT-1];
  assign state     = state_q;

endmodule

// File: tb/tb_mm_buf_responder.sv
// Self-checking bench for mm_buf_responder: table-driven request vectors,
// hand-written corner sequences, and a latency-aware response scoreboard.
module tb_mm_buf_responder;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 2048;
  localparam int LAT   = 2;

  logic          clk, rstn;
  logic          load_start, wr_valid, load_done, req_valid, serve_done;
  logic [AW-1:0] wr_addr, req_addr;
  logic [DW-1:0] wr_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [1:0]    state;
  logic [15:0]   req_count;
  logic          err_oob, err_proto;

  mm_buf_responder #(
    .DATA_W (DW), .ADDR_W (AW), .DEPTH (DEPTH), .RD_LAT (LAT)
  ) dut (
    .clk (clk), .rstn (rstn), .load_start (load_start), .wr_valid (wr_valid),
    .wr_addr (wr_addr), .wr_data (wr_data), .load_done (load_done),
    .req_valid (req_valid), .req_addr (req_addr), .serve_done (serve_done),
    .rsp_valid (rsp_valid), .rsp_data (rsp_data), .state (state),
    .req_count (req_count), .err_oob (err_oob), .err_proto (err_proto)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  logic [DW-1:0] exp_q[$];
  int            due_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      logic [DW-1:0] e;
      int            d;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 data %0h, expected no response (cycle %0d)", rsp_data, cyc);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("rsp_data", rsp_data, e);
        check("rsp_latency_cycle", DW'(cyc), DW'(d));
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1; step(); load_start = 1'b0;
  endtask

  task automatic pulse_load_done();
    load_done = 1'b1; step(); load_done = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  // acc=1: the request should be accepted and answered with e after LAT cycles.
  task automatic do_req(input logic [AW-1:0] a, input logic acc, input logic [DW-1:0] e);
    req_valid = 1'b1; req_addr = a;
    if (acc) begin
      exp_q.push_back(e);
      due_q.push_back(cyc + LAT);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_state", DW'(state), 32'd0);
    check("rst_rsp_valid", DW'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_req_count", DW'(req_count), 32'd0);
    check("rst_err_oob", DW'(err_oob), 32'd0);
    check("rst_err_proto", DW'(err_proto), 32'd0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp_data;
    logic          exp_err_oob;
  } vec_t;
  vec_t vecs[11];

  initial begin
    for (int i = 0; i < 8; i++) vecs[i] = '{AW'(i), DW'(i * 3), 1'b0};
    vecs[8]  = '{12'd2047, 32'hA5A5_0001, 1'b0};
    vecs[9]  = '{12'd2048, 32'h0, 1'b1};
    vecs[10] = '{12'd4095, 32'h0, 1'b1};

    rstn = 1'b0; load_start = 1'b0; wr_valid = 1'b0; load_done = 1'b0;
    req_valid = 1'b0; serve_done = 1'b0; wr_addr = '0; wr_data = '0; req_addr = '0;
    idle(3);
    check_reset_vals();
    rstn = 1'b1;
    step();

    // Fill
    pulse_load_start();
    check("state_load", DW'(state), 32'd1);
    for (int i = 0; i < 8; i++) do_write(AW'(i), DW'(i * 3));
    do_write(12'd2047, 32'hA5A5_0001);
    pulse_load_done();
    check("state_serve", DW'(state), 32'd2);
    check("count_clear", DW'(req_count), 32'd0);
    check("proto_clean", DW'(err_proto), 32'd0);

    // Single request, fixed latency
    do_req(12'd5, 1'b1, 32'd15);
    idle(4);
    check("count_single", DW'(req_count), 32'd1);

    // Back-to-back in-range table entries
    for (int i = 0; i < 8; i++) do_req(vecs[i].addr, 1'b1, vecs[i].exp_data);
    idle(4);
    check("count_b2b", DW'(req_count), 32'd9);
    check("oob_clean", DW'(err_oob), 32'd0);

    // Range boundary entries, checking the sticky flag per acceptance
    for (int i = 8; i < 11; i++) begin
      do_req(vecs[i].addr, 1'b1, vecs[i].exp_data);
      check("err_oob_vec", DW'(err_oob), DW'(vecs[i].exp_err_oob));
    end
    idle(4);
    check("count_oob", DW'(req_count), 32'd12);

    // Write attempted while serving: dropped and flagged
    do_write(12'd3, 32'hFFFF_FFFF);
    check("proto_wr_serve", DW'(err_proto), 32'd1);
    do_req(12'd3, 1'b1, 32'd9);
    idle(4);

    // serve_done together with a request: accepted, drains, then idles
    serve_done = 1'b1; req_valid = 1'b1; req_addr = 12'd6;
    exp_q.push_back(32'd18);
    due_q.push_back(cyc + LAT);
    step();
    serve_done = 1'b0; req_valid = 1'b0;
    check("state_drain", DW'(state), 32'd3);
    step();
    check("state_drain_rsp", DW'(state), 32'd3);
    step();
    check("state_idle_after", DW'(state), 32'd0);
    check("count_final", DW'(req_count), 32'd14);

    // Reset right after two requests: the first has already completed,
    // the second is still in flight and must never appear.
    pulse_load_start();
    pulse_load_done();
    check("count_reenter", DW'(req_count), 32'd0);
    do_req(12'd1, 1'b1, 32'd3);
    do_req(12'd2, 1'b0, 32'd0);
    rstn = 1'b0;
    step();
    check_reset_vals();
    rstn = 1'b1;
    idle(5);

    // Request while loading: dropped and flagged
    pulse_load_start();
    check("state_load2", DW'(state), 32'd1);
    do_req(12'd7, 1'b0, 32'd0);
    check("proto_req_load", DW'(err_proto), 32'd1);
    idle(3);
    pulse_load_done();
    check("state_serve2", DW'(state), 32'd2);

    // RAM contents survive reset; the dropped write left addr 3 intact
    do_req(12'd5, 1'b1, 32'd15);
    do_req(12'd2047, 1'b1, 32'hA5A5_0001);
    do_req(12'd3, 1'b1, 32'd9);
    idle(4);
    check("oob_after_rst", DW'(err_oob), 32'd0);

    // Counter saturation
    for (int i = 0; i < 65538; i++) do_req(12'd0, 1'b1, 32'd0);
    idle(4);
    check("count_saturate", DW'(req_count), 32'h0000_FFFF);

    serve_done = 1'b1; step(); serve_done = 1'b0;
    idle(2);
    check("state_idle_end", DW'(state), 32'd0);
    check("scoreboard_empty", DW'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
